layer_compositor: RTL
=====================

# layer_compositor

Parametrised, pipelined pixel compositor and successor to the single-sprite mixer in the Pac-Man video path. It merges NUM_LAYERS sprite layers (layer 0 = Pac-Man, others = ghosts/fruit), the maze layer and a background colour into one registered RGB stream using fixed priority, transparent-key masking, per-layer enable and frame-rate blinking. It also reports, once per frame, which sprite layers overlapped Pac-Man, for the game controller's collision logic. It sits between the per-object view modules and the VGA output register.

## Interface
Parameters:
- NUM_LAYERS, 4: sprite layers, 2..8; layer 0 is highest priority and is the collision reference.
- COLOR_W, 12: pixel colour width (4:4:4).
- TRANSPARENT, 12'h000: colour key treated as "not drawn".
- BLINK_FRAMES, 16: frames per blink half-period, ≥1.
- H_LAST, 799 / V_LAST, 524: last hCount/vCount of a frame.

Ports:
- clk  in  1  pixel-rate clock.
- rst  in  1  synchronous, active-high reset.
- bright  in  1  visible-area flag for the current pixel.
- hCount, vCount  in  10 each  current pixel coordinates.
- layer_fill  in  NUM_LAYERS  per-layer "pixel inside sprite box".
- layer_rgb  in  NUM_LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W].
- layer_en  in  NUM_LAYERS  layer enable, sampled every cycle.
- layer_blink  in  NUM_LAYERS  layer subject to blinking.
- maze_fill  in  1;  maze_rgb  in  COLOR_W.
- background  in  COLOR_W.
- rgb  out  COLOR_W  composited pixel, registered.
- collision_mask  out  NUM_LAYERS  bit i (i≥1) = layer i overlapped layer 0 this frame; bit 0 always 0.
- collision_valid  out  1  one-cycle pulse when collision_mask updates.

## Operation
- opaque[i] = layer_fill[i] & layer_en[i] & (layer_rgb[i] != TRANSPARENT) & ~(layer_blink[i] & blink_phase).
- Priority: ~bright → 0; else lowest-index opaque layer; else maze_rgb if maze_fill; else background.
- Collision: for each pixel with bright=1 and opaque[0]=1, OR opaque[i] (i≥1) into accumulator acc.
- End of frame: the pixel with hCount==H_LAST and vCount==V_LAST is end_of_frame (eof). Its effect is included in acc before publish.
- At publish: collision_mask ← acc (incl. eof pixel), collision_valid=1, acc ← contribution of the following pixel only (clear-and-load, no pixel lost).
- Blink: frame_cnt counts eof events 0..BLINK_FRAMES-1; on wrap, blink_phase toggles. blink_phase=1 hides blinking layers.
- layer_en/layer_blink changes take effect on the next pixel; no frame alignment.

## Timing
- Stage 1 (t+1): register opaque vector, all colours, bright, maze_fill, eof.
- Stage 2 (t+2): rgb register updated; acc updated from stage-1 regs.
- Latency: rgb for the pixel presented at cycle t appears at t+2. The hCount/vCount alignment of the downstream sync is shifted by 2 accordingly.
- eof pixel at cycle t → collision_valid high exactly at t+2, low at t+3. collision_mask holds until the next publish.
- Reset values: rgb=0, collision_mask=0, collision_valid=0, acc=0, frame_cnt=0, blink_phase=0, and all stage-1 regs 0 (incl. bright, so rgb stays 0 for 2 cycles after reset release).
- rst mid-frame: partial acc is discarded; no valid pulse until the next full eof.
- eof during reset: ignored.

## Structure
- Shared package/header pm_video_pkg: COLOR_W, TRANSPARENT, BLACK, H_LAST, V_LAST, layer index constants (PACMAN=0, GHOST0=1...).
- Sub-module collision_accumulator (NUM_LAYERS): takes stage-1 opaque, bright and eof; owns acc, collision_mask, collision_valid.
- Priority select is a generate loop in the top module.

## Test plan
- Layers 0 and 2 opaque at same pixel, rgb0=12'hFF0, rgb2=12'hF00 → rgb=12'hFF0 two cycles later. With layer_en[0]=0 → 12'hF00.
- Layer 0 fill=1 with rgb=TRANSPARENT, maze_fill=1 with maze_rgb=12'h00F → rgb=12'h00F. With bright=0 → 0.
- Frame where layer 3 overlaps layer 0 at one pixel and layer 1 overlaps on the eof pixel only → at eof+2, collision_valid=1 with mask=4'b1010. Next frame with no overlap → mask=4'b0000.
- BLINK_FRAMES=2, layer_blink[1]=1: layer 1 visible in frames 0-1, hidden in 2-3, visible in 4-5. Non-blink layers unaffected.
- rst asserted mid-frame after overlap → outputs 0 next cycle, no valid at the following eof beyond the post-reset accumulation. rgb=0 for 2 cycles after release.
- Back-to-back overlap on eof pixel and first pixel of next frame → the first is counted in the published mask, the second in the next frame's acc.

Source files
------------

// File: rtl/pm_video_pkg.sv
// Shared Pac-Man video constants: colour format, raster limits and sprite layer indices.
package pm_video_pkg;

    localparam int unsigned COLOR_W = 12;
    localparam int unsigned HV_W    = 10;
    localparam int unsigned H_LAST  = 799;
    localparam int unsigned V_LAST  = 524;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;
    localparam logic [COLOR_W-1:0] BLACK       = 12'h000;

    localparam int unsigned PACMAN = 0;
    localparam int unsigned GHOST0 = 1;
    localparam int unsigned GHOST1 = 2;
    localparam int unsigned GHOST2 = 3;

endpackage

// File: rtl/collision_accumulator.sv
// Per-frame OR of sprite layers that were drawn on the same visible pixel as Pac-Man.
module collision_accumulator #(
    parameter int unsigned NUM_LAYERS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LAYERS-1:0] opaque,
    input  logic                  bright,
    input  logic                  eof,
    output logic [NUM_LAYERS-1:0] collision_mask,
    output logic                  collision_valid
);
    import pm_video_pkg::*;

    logic [NUM_LAYERS-1:0] acc;
    logic [NUM_LAYERS-1:0] contrib_c;

    // Only pixels where Pac-Man himself is drawn can record an overlap.
    always_comb begin
        contrib_c         = opaque;
        contrib_c[PACMAN] = 1'b0;
        if (!(bright && opaque[PACMAN])) begin
            contrib_c = '0;
        end
    end

    // The eof pixel is folded into the published mask; acc restarts empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= '0;
            collision_mask  <= '0;
            collision_valid <= 1'b0;
        end else begin
            collision_valid <= eof;
            if (eof) begin
                collision_mask <= acc | contrib_c;
                acc            <= '0;
            end else begin
                acc <= acc | contrib_c;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite/maze/background compositor with blink control and per-frame collision report.
module layer_compositor #(
    parameter int unsigned        NUM_LAYERS   = 4,
    parameter int unsigned        COLOR_W      = pm_video_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] TRANSPARENT  = COLOR_W'(pm_video_pkg::TRANSPARENT),
    parameter int unsigned        BLINK_FRAMES = 16,
    parameter int unsigned        H_LAST       = pm_video_pkg::H_LAST,
    parameter int unsigned        V_LAST       = pm_video_pkg::V_LAST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bright,
    input  logic [pm_video_pkg::HV_W-1:0]   hCount,
    input  logic [pm_video_pkg::HV_W-1:0]   vCount,
    input  logic [NUM_LAYERS-1:0]           layer_fill,
    input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_rgb,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [NUM_LAYERS-1:0]           layer_blink,
    input  logic                            maze_fill,
    input  logic [COLOR_W-1:0]              maze_rgb,
    input  logic [COLOR_W-1:0]              background,
    output logic [COLOR_W-1:0]              rgb,
    output logic [NUM_LAYERS-1:0]           collision_mask,
    output logic                            collision_valid
);
    import pm_video_pkg::*;

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]              frame_cnt;
    logic                          blink_phase;
    logic [NUM_LAYERS-1:0]         opaque_c;
    logic                          eof_c;

    logic [NUM_LAYERS-1:0]         s1_opaque;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_layer_rgb;
    logic                          s1_maze_fill;
    logic [COLOR_W-1:0]            s1_maze_rgb;
    logic [COLOR_W-1:0]            s1_background;
    logic                          s1_bright;
    logic                          s1_eof;

    logic [COLOR_W-1:0]            chain_c [NUM_LAYERS+1];
    logic [COLOR_W-1:0]            rgb_next_c;

    always_comb begin
        opaque_c = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            opaque_c[i] = layer_fill[i] & layer_en[i]
                        & (layer_rgb[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                        & ~(layer_blink[i] & blink_phase);
        end
    end

    assign eof_c = (hCount == HV_W'(H_LAST)) && (vCount == HV_W'(V_LAST));

    // Blink phase flips after every BLINK_FRAMES end-of-frame pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (eof_c) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_opaque     <= '0;
            s1_layer_rgb  <= '0;
            s1_maze_fill  <= 1'b0;
            s1_maze_rgb   <= '0;
            s1_background <= '0;
            s1_bright     <= 1'b0;
            s1_eof        <= 1'b0;
        end else begin
            s1_opaque     <= opaque_c;
            s1_layer_rgb  <= layer_rgb;
            s1_maze_fill  <= maze_fill;
            s1_maze_rgb   <= maze_rgb;
            s1_background <= background;
            s1_bright     <= bright;
            s1_eof        <= eof_c;
        end
    end

    // Priority chain: lower layer index overrides everything behind it.
    assign chain_c[NUM_LAYERS] = s1_maze_fill ? s1_maze_rgb : s1_background;

    for (genvar gi = 0; gi < int'(NUM_LAYERS); gi++) begin : g_prio
        assign chain_c[gi] = s1_opaque[gi] ? s1_layer_rgb[gi*COLOR_W +: COLOR_W]
                                           : chain_c[gi+1];
    end

    assign rgb_next_c = s1_bright ? chain_c[0] : COLOR_W'(BLACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_next_c;
        end
    end

    collision_accumulator #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_collision_accumulator (
        .clk             (clk),
        .rst             (rst),
        .opaque          (s1_opaque),
        .bright          (s1_bright),
        .eof             (s1_eof),
        .collision_mask  (collision_mask),
        .collision_valid (collision_valid)
    );

endmodule
